// File: rtl/uart_top.sv
// 8N1 UART transmitter and receiver joined in internal loopback.
// The transmit line is registered; the receiver samples it through a 2-flop synchronizer.
module uart_top #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       tx_done
);

  localparam logic [15:0] LastCnt = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HalfCnt = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // Transmitter
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_line_q, tx_line_d;
  logic        tx_done_q, tx_done_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_done_d  = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        if (tx_start) begin
          tx_state_d = TxStart;
          tx_shift_d = tx_data;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_line_d  = 1'b0;
        end
      end
      TxStart: begin
        if (tx_cnt_q == LastCnt) begin
          tx_state_d = TxData;
          tx_cnt_d   = '0;
          tx_line_d  = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TxData: begin
        if (tx_cnt_q == LastCnt) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TxStop;
            tx_line_d  = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TxStop: begin
        if (tx_cnt_q == LastCnt) begin
          tx_state_d = TxIdle;
          tx_cnt_d   = '0;
          tx_done_d  = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // Receiver
  logic        sync1_q, sync2_q, rx_prev_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_done_q, rx_done_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_done_d  = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !sync2_q) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        // Mid-start re-check: a line already back high was a glitch.
        if (rx_cnt_q == HalfCnt) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = sync2_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RxData: begin
        if (rx_cnt_q == LastCnt) begin
          rx_cnt_d   = '0;
          rx_shift_d = {sync2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RxStop;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == LastCnt) begin
          rx_cnt_d   = '0;
          rx_state_d = RxIdle;
          if (sync2_q) begin
            rx_data_d = rx_shift_q;
            rx_done_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_done_q  <= 1'b0;
    end else begin
      sync1_q    <= tx_line_q;
      sync2_q    <= sync1_q;
      rx_prev_q  <= sync2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_done_q  <= rx_done_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rx_done = rx_done_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_top.sv
// Loopback bench for uart_top: bytes queued on send are matched against rx_data on rx_done,
// with latency, pulse-count and reset-abort checks.
module tb_uart_top;
  localparam int unsigned N = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;

  int cyc = 0;
  int vectors = 0;
  int errors = 0;
  int rx_pulses = 0;
  int tx_pulses = 0;
  logic [7:0] exp_q[$];

  uart_top #(.CLKS_PER_BIT(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done === 1'b1) rx_pulses++;
    if (tx_done === 1'b1) tx_pulses++;
  end

  task automatic wait_rx(output bit seen, output logic [7:0] d, output int at);
    seen = 1'b0; d = 8'h00; at = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rx_done === 1'b1) begin
        seen = 1'b1; d = rx_data; at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_tx(output bit seen, output int at);
    seen = 1'b0; at = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1) begin
        seen = 1'b1; at = cyc;
        break;
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input bit push, output int acc);
    @(negedge clk);
    tx_data = b; tx_start = 1'b1;
    if (push) exp_q.push_back(b);
    @(negedge clk);
    tx_start = 1'b0; acc = cyc;
  endtask

  task automatic test_reset;
    rst = 1'b1; tx_start = 1'b1; tx_data = 8'h77;
    repeat (10) @(negedge clk);
    vectors++;
    if (rx_data !== 8'h00 || rx_done !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rx_data=%h rx_done=%b tx_done=%b, want 00 0 0",
               rx_data, rx_done, tx_done);
    end
    vectors++;
    if (dut.tx_line_q !== 1'b1) begin
      errors++; $display("FAIL reset_line: line=%b, want 1", dut.tx_line_q);
    end
    rst = 1'b0; tx_start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dut.tx_line_q !== 1'b1) begin
        vectors++; errors++;
        $display("FAIL reset_start_ignored: line=%b at cycle %0d, want 1", dut.tx_line_q, i);
        break;
      end
    end
    #1;
    vectors++;
    if (rx_pulses != 0 || tx_pulses != 0) begin
      errors++; $display("FAIL reset_no_pulse: rx=%0d tx=%0d pulses, want 0 0", rx_pulses, tx_pulses);
    end
  endtask

  task automatic test_first_frame;
    bit seen; logic [7:0] d; logic [7:0] exp; int at; int acc; int rx0; int tx0;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    #1; rx0 = rx_pulses; tx0 = tx_pulses;
    rst = 1'b0; tx_data = 8'hA5; tx_start = 1'b1; exp_q.push_back(8'hA5);
    @(negedge clk);
    tx_start = 1'b0; acc = cyc;
    vectors++;
    if (dut.tx_line_q !== 1'b0) begin
      errors++; $display("FAIL a5_start_bit: line=%b after accept, want 0", dut.tx_line_q);
    end
    wait_rx(seen, d, at);
    vectors++;
    if (!seen) begin
      errors++; $display("FAIL a5_rx_timeout: no rx_done, want one");
    end else begin
      exp = exp_q.pop_front();
      vectors++;
      if (d !== exp) begin errors++; $display("FAIL a5_rx_data: got %h, want %h", d, exp); end
      vectors++;
      if (at - acc < 152 || at - acc > 156) begin
        errors++; $display("FAIL a5_rx_latency: got %0d, want 152..156", at - acc);
      end
      @(negedge clk);
      vectors++;
      if (rx_done !== 1'b0) begin errors++; $display("FAIL a5_rx_width: rx_done=%b, want 0", rx_done); end
    end
    wait_tx(seen, at);
    vectors++;
    if (!seen || at - acc != 160) begin
      errors++; $display("FAIL a5_tx_done: seen=%b latency=%0d, want 1 160", seen, at - acc);
    end
    repeat (20) @(negedge clk);
    #1; vectors++;
    if (rx_pulses - rx0 != 1 || tx_pulses - tx0 != 1) begin
      errors++; $display("FAIL a5_pulse_count: rx=%0d tx=%0d, want 1 1", rx_pulses - rx0, tx_pulses - tx0);
    end
  endtask

  task automatic test_patterns;
    logic [7:0] pats[3];
    bit seen; logic [7:0] d; logic [7:0] exp; int at; int acc; int rx0;
    pats = '{8'h00, 8'hFF, 8'h01};
    #1; rx0 = rx_pulses;
    for (int k = 0; k < 3; k++) begin
      send(pats[k], 1'b1, acc);
      wait_rx(seen, d, at);
      vectors++;
      if (!seen) begin
        errors++; $display("FAIL pat%0d_rx_timeout: no rx_done, want %h", k, pats[k]);
      end else begin
        exp = exp_q.pop_front();
        vectors++;
        if (d !== exp) begin errors++; $display("FAIL pat%0d_rx_data: got %h, want %h", k, d, exp); end
      end
      wait_tx(seen, at);
      vectors++;
      if (!seen) begin errors++; $display("FAIL pat%0d_tx_timeout: no tx_done, want one", k); end
    end
    repeat (5) @(negedge clk);
    #1; vectors++;
    if (rx_pulses - rx0 != 3) begin
      errors++; $display("FAIL pat_rx_count: got %0d pulses, want 3", rx_pulses - rx0);
    end
  endtask

  task automatic test_back_to_back;
    bit seen; logic [7:0] d; logic [7:0] exp; int at; int acc; int acc2; int tdone;
    send(8'hC3, 1'b1, acc);
    wait_rx(seen, d, at);
    vectors++;
    if (!seen) begin
      errors++; $display("FAIL b2b_c3_rx: no rx_done, want c3");
    end else begin
      exp = exp_q.pop_front();
      vectors++;
      if (d !== exp) begin errors++; $display("FAIL b2b_c3_data: got %h, want %h", d, exp); end
    end
    wait_tx(seen, tdone);
    vectors++;
    if (!seen) begin errors++; $display("FAIL b2b_c3_tx: no tx_done, want one"); end
    tx_data = 8'h3C; tx_start = 1'b1; exp_q.push_back(8'h3C);
    @(negedge clk);
    tx_start = 1'b0; acc2 = cyc;
    vectors++;
    if (dut.tx_line_q !== 1'b0 || acc2 - tdone != 1) begin
      errors++;
      $display("FAIL b2b_restart: line=%b offset=%0d, want 0 1", dut.tx_line_q, acc2 - tdone);
    end
    wait_rx(seen, d, at);
    vectors++;
    if (!seen) begin
      errors++; $display("FAIL b2b_3c_rx: no rx_done, want 3c");
    end else begin
      exp = exp_q.pop_front();
      vectors++;
      if (d !== exp) begin errors++; $display("FAIL b2b_3c_data: got %h, want %h", d, exp); end
    end
    wait_tx(seen, at);
    vectors++;
    if (!seen || at - acc2 != 160) begin
      errors++; $display("FAIL b2b_3c_tx: seen=%b latency=%0d, want 1 160", seen, at - acc2);
    end
  endtask

  task automatic test_ignore_busy;
    bit seen; logic [7:0] d; logic [7:0] exp; int at; int acc; int rx0; int tx0;
    #1; rx0 = rx_pulses; tx0 = tx_pulses;
    send(8'hAA, 1'b1, acc);
    repeat (40) @(negedge clk);
    tx_data = 8'h55; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_rx(seen, d, at);
    vectors++;
    if (!seen) begin
      errors++; $display("FAIL busy_rx: no rx_done, want aa");
    end else begin
      exp = exp_q.pop_front();
      vectors++;
      if (d !== exp) begin errors++; $display("FAIL busy_rx_data: got %h, want %h", d, exp); end
    end
    wait_tx(seen, at);
    vectors++;
    if (!seen || at - acc != 160) begin
      errors++; $display("FAIL busy_tx: seen=%b latency=%0d, want 1 160", seen, at - acc);
    end
    repeat (200) @(negedge clk);
    #1; vectors++;
    if (rx_pulses - rx0 != 1 || tx_pulses - tx0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL busy_counts: rx=%0d tx=%0d pending=%0d, want 1 1 0",
               rx_pulses - rx0, tx_pulses - tx0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    bit seen; logic [7:0] d; logic [7:0] exp; int at; int acc; int rx0; int tx0;
    send(8'h5A, 1'b0, acc);
    repeat (80) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (rx_data !== 8'h00 || rx_done !== 1'b0 || tx_done !== 1'b0 || dut.tx_line_q !== 1'b1) begin
      errors++;
      $display("FAIL midrst_clear: rx_data=%h rx_done=%b tx_done=%b line=%b, want 00 0 0 1",
               rx_data, rx_done, tx_done, dut.tx_line_q);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1; rx0 = rx_pulses; tx0 = tx_pulses;
    repeat (200) @(negedge clk);
    #1; vectors++;
    if (rx_pulses != rx0 || tx_pulses != tx0) begin
      errors++; $display("FAIL midrst_no_pulse: rx=%0d tx=%0d, want 0 0", rx_pulses - rx0, tx_pulses - tx0);
    end
    send(8'h96, 1'b1, acc);
    wait_rx(seen, d, at);
    vectors++;
    if (!seen) begin
      errors++; $display("FAIL midrst_96_rx: no rx_done, want 96");
    end else begin
      exp = exp_q.pop_front();
      vectors++;
      if (d !== exp) begin errors++; $display("FAIL midrst_96_data: got %h, want %h", d, exp); end
    end
    wait_tx(seen, at);
    vectors++;
    if (!seen) begin errors++; $display("FAIL midrst_96_tx: no tx_done, want one"); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_patterns();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_top.md
UART_TOP -- requirements
Module: uart_top

Interface
REQ-001 The block SHALL have one parameter: CLKS_PER_BIT, default 16, clock cycles per serial bit; legal values 4 to 65535.
REQ-002 The port clk SHALL be an input, 1 bit wide: the single system clock; all logic is rising-edge triggered.
REQ-003 The port rst SHALL be an input, 1 bit wide: reset is synchronous and active-high.
REQ-004 The port tx_start SHALL be an input, 1 bit wide: request to transmit tx_data, sampled on the clk edge.
REQ-005 The port tx_data SHALL be an input, 8 bits wide: byte to transmit, captured on the edge that accepts tx_start.
REQ-006 The port rx_data SHALL be an output, 8 bits wide: last correctly framed received byte, registered and held until the next valid byte.
REQ-007 The port rx_done SHALL be an output, 1 bit wide: one-cycle pulse when rx_data has been updated with a valid byte.
REQ-008 The port tx_done SHALL be an output, 1 bit wide: one-cycle pulse when a transmit frame completes.

Function
REQ-009 The block SHALL contain a transmitter and a receiver, with the transmitter's serial output wired internally to the receiver's serial input (loopback); no serial pins are exposed.
REQ-010 The frame SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each bit CLKS_PER_BIT cycles long; the idle line SHALL be 1.
REQ-011 The transmitter FSM SHALL have states IDLE, START, DATA, STOP: IDLE->START on tx_start=1; START->DATA after N cycles; DATA->STOP after 8 bits; STOP->IDLE after N cycles.
REQ-012 The serial line SHALL go low on the first cycle after the edge that accepts tx_start, and the frame SHALL last exactly 10*CLKS_PER_BIT cycles.
REQ-013 tx_done SHALL pulse high for exactly one cycle, coinciding with the STOP->IDLE transition (10*CLKS_PER_BIT cycles after acceptance).
REQ-014 The transmitter SHALL accept a new tx_start in the cycle immediately after tx_done, allowing back-to-back frames with no idle gap.
REQ-015 A tx_start asserted while the transmitter is not in IDLE SHALL be ignored; tx_data changes during a frame SHALL NOT affect the frame in flight.
REQ-016 The receiver SHALL pass the line through a 2-flop synchronizer whose flops reset to 1.
REQ-017 The receiver FSM SHALL have states IDLE, START, DATA, STOP.
REQ-018 Receiver IDLE->START SHALL occur on a synchronized 1->0 transition.
REQ-019 In START, the receiver SHALL re-sample the line at CLKS_PER_BIT/2 (integer division): if 0, go to DATA; if 1, treat it as a glitch and return to IDLE.
REQ-020 In DATA, the receiver SHALL sample each bit every CLKS_PER_BIT cycles at mid-bit, shifting LSB first.
REQ-021 In STOP, the receiver SHALL sample at mid-stop-bit: if 1, load rx_data and pulse rx_done for one cycle; if 0 (framing error), discard the byte, leave rx_data unchanged, and give no rx_done pulse; in both cases return to IDLE.
REQ-022 rx_done SHALL assert between 9.5*CLKS_PER_BIT and 9.5*CLKS_PER_BIT+4 cycles after the transmit acceptance edge, and before tx_done.
REQ-023 Bit and cycle counters SHALL be sized for the maximum CLKS_PER_BIT and SHALL not wrap within a bit.

Reset
REQ-024 While rst=1 on a clock edge, both FSMs SHALL go to IDLE and the serial line SHALL be driven to 1.
REQ-025 While rst=1 on a clock edge, rx_data SHALL be cleared to 8'h00 and rx_done and tx_done SHALL be cleared to 0.
REQ-026 While rst=1 on a clock edge, all counters and shift registers SHALL be cleared.
REQ-027 Asserting rst mid-frame SHALL abort both transmit and receive with no rx_done or tx_done pulse; the partial byte SHALL be lost.
REQ-028 tx_start asserted during reset SHALL be ignored.
REQ-029 The first frame SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-030 Scenario (CLKS_PER_BIT=16): rst high for 10 cycles, then tx_data=8'hA5 with tx_start pulsed for 1 cycle -> rx_data=8'hA5 with one rx_done pulse at about cycle 152, then one tx_done pulse at cycle 160.
REQ-031 Scenario: transmit bytes 8'h00, then 8'hFF, then 8'h01 -> rx_data equals each byte in turn, with exactly one rx_done per frame.
REQ-032 Scenario: back-to-back transmission, tx_start=1 with 8'h3C in the cycle after tx_done of 8'hC3 -> both bytes received in order, with no gap on the line.
REQ-033 Scenario: tx_start pulsed with 8'h55 mid-frame while 8'hAA is transmitting -> only 8'hAA is received, and exactly one tx_done pulse occurs.
REQ-034 Scenario: rst asserted at cycle 80 of a frame -> outputs are cleared, no rx_done or tx_done pulse occurs, and a subsequent frame with 8'h96 is received correctly.
